bme280_temp_comp: RTL and testbench

Integer temperature compensation stage for the BME280 weather station. Sits directly downstream of `bme280_reader`, taking its raw 20-bit `TempBin` and the DigT1..DigT3 trim words. Produces a signed temperature in 0.01 °C and the `TFine` term needed by later pressure and humidity compensation stages. Its outputs feed the bin2bcd / seven-segment display path. Evaluates the Bosch datasheet int32 formula with one shared multiplier sequenced by a small FSM.

---
 rtl/bme280_temp_comp_pkg.sv | 25 ++
 rtl/bme280_mul.sv | 16 +
 rtl/bme280_temp_comp.sv | 147 ++++++++++++++
 tb/tb_bme280_temp_comp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bme280_temp_comp_pkg.sv
// Shared constants for the BME280 integer compensation stages: FSM encodings,
// datasheet shift amounts, rounding constant and shared multiplier geometry.
package bme280_temp_comp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_M1   = 3'd1,
      ST_M2   = 3'd2,
      ST_M3   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   localparam int SH_ADC_T1 = 3;
   localparam int SH_ADC_T2 = 4;
   localparam int SH_VAR1   = 11;
   localparam int SH_SQ     = 12;
   localparam int SH_VAR2   = 14;
   localparam int SH_TEMP   = 8;
   localparam int RND_TEMP  = 128;

   localparam int MUL_AW = 34;
   localparam int MUL_BW = 17;
   localparam int MUL_PW = MUL_AW + MUL_BW;

endpackage

// File: rtl/bme280_mul.sv
// Combinational signed multiplier shared by the compensation stages; zero latency,
// full-precision product so callers choose their own shift and truncation.
module bme280_mul
   import bme280_temp_comp_pkg::*;
#(
   parameter int AW = MUL_AW,
   parameter int BW = MUL_BW
) (
   input  logic signed [AW-1:0]    i_a,
   input  logic signed [BW-1:0]    i_b,
   output logic signed [AW+BW-1:0] o_p
);

   assign o_p = i_a * i_b;

endmodule

// File: rtl/bme280_temp_comp.sv
// BME280 temperature compensation (datasheet int32 formula) on one shared multiplier.
// Result 4 cycles after an accepted Start; Start is dropped while Busy, no queueing.
module bme280_temp_comp
   import bme280_temp_comp_pkg::*;
#(
   parameter int TW = 20,
   parameter int OW = 32
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Start,
   input  logic [TW-1:0] TempBin,
   input  logic [15:0]   DigT1,
   input  logic [15:0]   DigT2,
   input  logic [15:0]   DigT3,
   output logic          Busy,
   output logic          Done,
   output logic [OW-1:0] Temp,
   output logic [OW-1:0] TFine
);

   state_t r_state;
   state_t w_state_nxt;

   logic [TW-1:0]        r_adc;
   logic [15:0]          r_t1;
   logic signed [15:0]   r_t2;
   logic signed [15:0]   r_t3;
   logic signed [OW-1:0] r_var1;
   logic signed [OW-1:0] r_sq;
   logic signed [OW-1:0] r_var2;
   logic signed [OW-1:0] r_tfine;
   logic signed [OW-1:0] r_temp;
   logic                 r_done;

   logic [OW-1:0]            w_adc_ext;
   logic [OW-1:0]            w_t1_ext;
   logic signed [OW-1:0]     w_diff1;
   logic signed [OW-1:0]     w_diff2;
   logic signed [MUL_AW-1:0] w_mul_a;
   logic signed [MUL_BW-1:0] w_mul_b;
   logic signed [MUL_PW-1:0] w_mul_p;
   logic signed [OW-1:0]     w_tfine_nxt;
   logic signed [OW+2:0]     w_tfine_x;
   logic signed [OW+2:0]     w_temp_acc;

   assign w_adc_ext = {{(OW-TW){1'b0}}, r_adc};
   assign w_t1_ext  = {{(OW-16){1'b0}}, r_t1};
   assign w_diff1   = signed'((w_adc_ext >> SH_ADC_T1) - (w_t1_ext << 1));
   assign w_diff2   = signed'((w_adc_ext >> SH_ADC_T2) - w_t1_ext);

   // w_diff2 always lies within +/-65535, so its low 17 bits are the exact signed value.
   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      case (r_state)
         ST_M1: begin
            w_mul_a = {{(MUL_AW-OW){w_diff1[OW-1]}}, w_diff1};
            w_mul_b = {r_t2[15], r_t2};
         end
         ST_M2: begin
            w_mul_a = {{(MUL_AW-OW){w_diff2[OW-1]}}, w_diff2};
            w_mul_b = w_diff2[MUL_BW-1:0];
         end
         ST_M3: begin
            w_mul_a = {{(MUL_AW-OW){r_sq[OW-1]}}, r_sq};
            w_mul_b = {r_t3[15], r_t3};
         end
         default: ;
      endcase
   end

   bme280_mul #(
      .AW (MUL_AW),
      .BW (MUL_BW)
   ) u_mul (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_mul_p)
   );

   assign w_tfine_nxt = r_var1 + r_var2;
   assign w_tfine_x   = {{3{w_tfine_nxt[OW-1]}}, w_tfine_nxt};
   assign w_temp_acc  = (w_tfine_x <<< 2) + w_tfine_x + (OW+3)'(RND_TEMP);

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (Start) w_state_nxt = ST_M1;
         ST_M1:   w_state_nxt = ST_M2;
         ST_M2:   w_state_nxt = ST_M3;
         ST_M3:   w_state_nxt = ST_FIN;
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_adc   <= '0;
         r_t1    <= '0;
         r_t2    <= '0;
         r_t3    <= '0;
         r_var1  <= '0;
         r_sq    <= '0;
         r_var2  <= '0;
         r_tfine <= '0;
         r_temp  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_adc <= TempBin;
                  r_t1  <= DigT1;
                  r_t2  <= DigT2;
                  r_t3  <= DigT3;
               end
            end
            ST_M1:  r_var1 <= OW'(w_mul_p >>> SH_VAR1);
            ST_M2:  r_sq   <= OW'(w_mul_p >>> SH_SQ);
            ST_M3:  r_var2 <= OW'(w_mul_p >>> SH_VAR2);
            ST_FIN: begin
               r_tfine <= w_tfine_nxt;
               r_temp  <= OW'(w_temp_acc >>> SH_TEMP);
               r_done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Busy  = (r_state != ST_IDLE);
   assign Done  = r_done;
   assign Temp  = r_temp;
   assign TFine = r_tfine;

endmodule

// File: tb/tb_bme280_temp_comp.sv
// Scoreboard bench for bme280_temp_comp: stimulus pushes expected results,
// a negedge monitor pops and compares on every Done pulse.
module tb_bme280_temp_comp;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Start;
   logic [19:0] TempBin;
   logic [15:0] DigT1;
   logic [15:0] DigT2;
   logic [15:0] DigT3;
   logic        Busy;
   logic        Done;
   logic [31:0] Temp;
   logic [31:0] TFine;

   typedef struct packed {
      int tf;
      int tmp;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   bme280_temp_comp #(.TW(20), .OW(32)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Start   (Start),
      .TempBin (TempBin),
      .DigT1   (DigT1),
      .DigT2   (DigT2),
      .DigT3   (DigT3),
      .Busy    (Busy),
      .Done    (Done),
      .Temp    (Temp),
      .TFine   (TFine)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void ref_model(input int adc, input int t1, input int t2, input int t3,
                                     output int tf, output int tmp);
      longint v1, d, v2;
      int var1, sq32, var2;
      v1   = ((longint'(adc) >>> 3) - (longint'(t1) * 2)) * longint'(t2);
      var1 = int'(v1 >>> 11);
      d    = (longint'(adc) >>> 4) - longint'(t1);
      sq32 = int'((d * d) >>> 12);
      v2   = longint'(sq32) * longint'(t3);
      var2 = int'(v2 >>> 14);
      tf   = var1 + var2;
      tmp  = int'((longint'(tf) * 5 + 128) >>> 8);
   endfunction

   always @(negedge Clk) begin
      exp_t e;
      if (Done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=Done expected=no Done (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("tfine", int'(TFine), e.tf);
            chk("temp", int'(Temp), e.tmp);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(negedge Clk);
   endtask

   // Called at a negedge; Start is sampled at the next posedge, Done follows 4 edges later.
   task automatic pulse(input int adc, input int t1, input int t2, input int t3,
                        input bit push, input int etf, input int etmp);
      TempBin = adc[19:0];
      DigT1   = t1[15:0];
      DigT2   = t2[15:0];
      DigT3   = t3[15:0];
      Start   = 1'b1;
      if (push) sb.push_back('{etf, etmp, cyc + 5});
      tick();
      Start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  d0;
      bit  seen;
      int  adc, t1, t2, t3, etf, etmp;
      logic [15:0] rnd16;

      Rst_n = 1'b0; Start = 1'b0; TempBin = '0; DigT1 = '0; DigT2 = '0; DigT3 = '0;
      repeat (3) tick();
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_temp", int'(Temp), 0);
      chk("rst_tfine", int'(TFine), 0);
      Rst_n = 1'b1;
      tick();

      // Datasheet vector plus Busy window
      pulse(519888, 27504, 26435, -1000, 1'b1, 128422, 2508);
      chk("busy_k", int'(Busy), 1);
      repeat (3) tick();
      chk("busy_k3", int'(Busy), 1);
      tick();
      chk("busy_k4", int'(Busy), 0);
      repeat (2) tick();

      // Floor rounding on negative values
      pulse(0, 27504, 26435, -1000, 1'b1, -721301, -14088);
      repeat (6) tick();

      // Starts while busy are dropped, latched inputs are not disturbed
      d0 = done_cnt;
      pulse(519888, 27504, 26435, -1000, 1'b1, 128422, 2508);
      TempBin = 20'd0; Start = 1'b1;
      tick();
      TempBin = 20'd12345; DigT1 = 16'd1;
      tick();
      Start = 1'b0;
      repeat (6) tick();
      chk("ignored_done_count", done_cnt - d0, 1);

      // Back-to-back: new Start in the Done cycle
      pulse(519888, 27504, 26435, -1000, 1'b1, 128422, 2508);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (Done) seen = 1'b1;
      end
      chk("b2b_first_done_seen", int'(seen), 1);
      if (seen) pulse(0, 27504, 26435, -1000, 1'b1, -721301, -14088);
      repeat (6) tick();

      // Reset mid-computation aborts with no Done
      d0 = done_cnt;
      pulse(519888, 27504, 26435, -1000, 1'b0, 0, 0);
      tick();
      Rst_n = 1'b0;
      tick();
      chk("abort_busy", int'(Busy), 0);
      chk("abort_temp", int'(Temp), 0);
      chk("abort_tfine", int'(TFine), 0);
      Rst_n = 1'b1;
      repeat (6) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      pulse(519888, 27504, 26435, -1000, 1'b1, 128422, 2508);
      repeat (6) tick();

      // Start held high: restarts in the cycle after each FIN
      TempBin = 20'd519888; DigT1 = 16'd27504; DigT2 = 16'd26435; DigT3 = 16'hFC18;
      Start = 1'b1;
      sb.push_back('{128422, 2508, cyc + 5});
      sb.push_back('{-721301, -14088, cyc + 10});
      tick();
      TempBin = 20'd0;
      repeat (5) tick();
      Start = 1'b0;
      repeat (12) tick();

      // Random sweep against the int32 reference, issued at full rate
      for (int n = 0; n < 1000; n++) begin
         adc   = int'($urandom_range(0, 1048575));
         t1    = int'($urandom_range(0, 65535));
         rnd16 = 16'($urandom);
         t2    = int'($signed(rnd16));
         rnd16 = 16'($urandom);
         t3    = int'($signed(rnd16));
         ref_model(adc, t1, t2, t3, etf, etmp);
         pulse(adc, t1, t2, t3, 1'b1, etf, etmp);
         TempBin = 20'($urandom); DigT1 = 16'($urandom);
         DigT2 = 16'($urandom); DigT3 = 16'($urandom);
         repeat (4) tick();
      end

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("scoreboard_drained", sb.size(), 0);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
